i2c_burst_writer: RTL and testbench

I2C_BURST_WRITER -- requirements
Module: i2c_burst_writer

---
 rtl/i2c_burst_writer.sv | 167 ++++++++++++++++
 tb/tb_i2c_burst_writer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_burst_writer.sv
// Write-only I2C master: START, up to NBYTES bytes MSB first with ACK slots, STOP, bus-free gap.
// Optional macro I2C_ACK_CHECK_EN: a NACK aborts the remaining bytes and raises o_nack.
module i2c_burst_writer #(
  parameter int NBYTES  = 3,
  parameter int CLK_DIV = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [8*NBYTES-1:0]         i_data,
  input  logic [$clog2(NBYTES+1)-1:0] i_len,
  output logic                        o_busy,
  output logic                        o_finished,
  output logic                        o_nack,
  output logic                        o_scl,
  inout  wire                         o_sda
);
  localparam int DW = 8*NBYTES;
  localparam int LW = $clog2(NBYTES+1);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, FREE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            phase, phase_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [LW-1:0]   bytes_left, left_n;
  logic [DW-1:0]   shreg, sh_n;
  logic            scl_q, scl_n;
  logic            sda_low_q, sda_low_n;
  logic            busy_q, fin_q, fin_n;
  logic [LW-1:0]   len_eff;
  logic            last;
  logic            ack_nack;

  assign len_eff = (i_len > LW'(NBYTES)) ? LW'(NBYTES) : i_len;
  assign last    = (cnt == CW'(CLK_DIV-1));

`ifdef I2C_ACK_CHECK_EN
  assign ack_nack = o_sda;
`else
  assign ack_nack = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = last ? '0 : cnt + 1'b1;
    phase_n = phase;
    bit_n   = bit_cnt;
    left_n  = bytes_left;
    sh_n    = shreg;
    fin_n   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (i_start) begin
          if (len_eff != '0) begin
            state_n = START;
            sh_n    = i_data;
            left_n  = len_eff;
          end else begin
            fin_n = 1'b1;
          end
        end
      end
      START: if (last) begin
        state_n = BIT;
        phase_n = 1'b0;
        bit_n   = '0;
      end
      // Shifting only at the end of the high phase keeps SDA stable while SCL is high
      BIT: if (last) begin
        phase_n = ~phase;
        if (phase) begin
          sh_n = shreg << 1;
          if (bit_cnt == 3'd7) begin
            state_n = ACK;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      ACK: if (last) begin
        phase_n = ~phase;
        if (phase) begin
          left_n = bytes_left - 1'b1;
          if (bytes_left == LW'(1) || ack_nack) state_n = STOP;
          else                                  state_n = BIT;
        end
      end
      STOP: if (last) begin
        phase_n = ~phase;
        if (phase) state_n = FREE;
      end
      FREE: if (last) begin
        state_n = IDLE;
        fin_n   = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // Bus pins are registered from the next state so they never glitch on decode
    scl_n     = 1'b1;
    sda_low_n = 1'b0;
    case (state_n)
      START: sda_low_n = 1'b1;
      BIT: begin
        scl_n     = phase_n;
        sda_low_n = ~sh_n[DW-1];
      end
      ACK:  scl_n = phase_n;
      STOP: begin
        scl_n     = phase_n;
        sda_low_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      bytes_left <= '0;
      shreg      <= '0;
      scl_q      <= 1'b1;
      sda_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      phase      <= phase_n;
      bit_cnt    <= bit_n;
      bytes_left <= left_n;
      shreg      <= sh_n;
      scl_q      <= scl_n;
      sda_low_q  <= sda_low_n;
      busy_q     <= (state_n != IDLE);
      fin_q      <= fin_n;
    end
  end

`ifdef I2C_ACK_CHECK_EN
  logic nack_q;
  logic accept;
  assign accept = (state == IDLE) && i_start && (len_eff != '0);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                                      nack_q <= 1'b0;
    else if (accept)                                 nack_q <= 1'b0;
    else if (state == ACK && last && phase && ack_nack) nack_q <= 1'b1;
  end
  assign o_nack = nack_q;
`else
  assign o_nack = 1'b0;
`endif

  assign o_busy     = busy_q;
  assign o_finished = fin_q;
  assign o_scl      = scl_q;
  assign o_sda      = sda_low_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_burst_writer.sv
// Bench for i2c_burst_writer: timeline model of the bus waveform plus an independent I2C decoder.
module tb_i2c_burst_writer;
  localparam int NB = 3;
  localparam int C  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] data = '0;
  logic [1:0]  len = '0;
  logic        busy, fin, nack, scl;
  wire         sda;
  logic        slave_low = 1'b0;

  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_burst_writer #(.NBYTES(NB), .CLK_DIV(C)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_data(data), .i_len(len),
    .o_busy(busy), .o_finished(fin), .o_nack(nack), .o_scl(scl), .o_sda(sda)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction is a timeline indexed by cycles since accept
  int         m_pos = -1, m_D = 0, m_n = 0, m_stop = 0, m_nack_at = -1;
  logic [7:0] m_bytes [NB];
  bit         m_fin = 1'b0, m_nack = 1'b0, m_will_nack = 1'b0;
  int         nack_at = -1;

  function automatic void expect_at(input int p, output logic e_scl, output logic e_line,
                                    output logic e_slave);
    int q, s, w, b, i;
    e_slave = 1'b0;
    e_scl   = 1'b1;
    e_line  = 1'b1;
    if (p < 0) begin
    end else if (p < C) begin
      e_line = 1'b0;
    end else if (p < m_stop) begin
      q = p - C;  s = q / (2*C);  w = q % (2*C);  b = s / 9;  i = s % 9;
      e_scl = (w >= C);
      if (i < 8) e_line = m_bytes[b][7-i];
      else begin
        e_slave = (b != m_nack_at);
        e_line  = !e_slave;
      end
    end else if (p < m_stop + 2*C) begin
      e_scl  = ((p - m_stop) >= C);
      e_line = 1'b0;
    end
  endfunction

  initial begin
    bit f; int L; logic es, el, sl;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pos = -1; m_fin = 1'b0; m_nack = 1'b0;
        slave_low <= 1'b0;
      end else begin
        f = 1'b0;
        if (m_pos >= 0) begin
          m_pos++;
          if (m_pos == m_D) begin
            m_pos = -1; f = 1'b1;
          end else if (m_pos == m_stop && m_will_nack) m_nack = 1'b1;
        end else if (start) begin
          L = (int'(len) > NB) ? NB : int'(len);
          if (L == 0) f = 1'b1;
          else begin
            for (int b = 0; b < NB; b++) m_bytes[b] = data[8*(NB-b)-1 -: 8];
            m_nack_at = nack_at; m_n = L; m_will_nack = 1'b0;
`ifdef I2C_ACK_CHECK_EN
            if (nack_at >= 0 && nack_at < L) begin
              m_n = nack_at + 1; m_will_nack = 1'b1;
            end
`endif
            m_stop = C + 18*C*m_n; m_D = m_stop + 3*C; m_pos = 0; m_nack = 1'b0;
          end
        end
        m_fin = f;
        expect_at(m_pos, es, el, sl);
        slave_low <= sl;
      end
    end
  end

  initial begin
    logic es, el, ed;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        expect_at(m_pos, es, el, ed);
        chk("scl", scl, es);
        chk("sda", sda, el);
        chk("busy", busy, m_pos >= 0);
        chk("finished", fin, m_fin);
        chk("nack", nack, m_nack);
      end
    end
  end

  // Independent bus decoder
  int         rises = 0, n_start = 0, n_stop = 0, busy_cnt = 0, n_busy_rise = 0, scl_low_cnt = 0;
  logic [7:0] cur = '0;
  logic [7:0] dec [$];
  initial begin
    logic ps, pd, pb;
    ps = 1'b1; pd = 1'b1; pb = 1'b0;
    forever begin
      @(negedge clk);
      if (ps && scl && pd && !sda) begin
        n_start++; rises = 0; dec.delete();
      end
      if (!ps && scl) begin
        rises++;
        if ((rises - 1) % 9 < 8) cur = {cur[6:0], sda};
        if ((rises - 1) % 9 == 7) dec.push_back(cur);
      end
      if (ps && scl && !pd && sda) begin
        n_stop++; rises--;
      end
      if (busy && !pb) begin
        busy_cnt = 0; n_busy_rise++;
      end
      if (busy) busy_cnt++;
      if (!scl) scl_low_cnt++;
      ps = scl; pd = sda; pb = busy;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [23:0] d, input logic [1:0] l, input int na);
    nack_at = na; data = d; len = l; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_fin();
    int k = 0;
    while (!fin && k < 1000) begin
      step(); k++;
    end
    chk("fin_wait", fin, 1);
    step(); step();
  endtask

  initial begin
    int s0, p0, b0, l0;
    step(); step();
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fin", fin, 0);
    chk("rst_nack", nack, 0);
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    step(); step();

    // Three bytes, all acknowledged
    s0 = n_start; p0 = n_stop;
    launch(24'h341E00, 2'd3, -1);
    wait_fin();
    chk("t1_start", n_start - s0, 1);
    chk("t1_stop", n_stop - p0, 1);
    chk("t1_rises", rises, 27);
    chk("t1_nbytes", dec.size(), 3);
    chk("t1_b0", dec[0], 8'h34);
    chk("t1_b1", dec[1], 8'h1E);
    chk("t1_b2", dec[2], 8'h00);
    chk("t1_busy", busy_cnt, 116);
    chk("t1_nack", nack, 0);

    // Single byte
    launch(24'hA5FFFF, 2'd1, -1);
    wait_fin();
    chk("t2_rises", rises, 9);
    chk("t2_nbytes", dec.size(), 1);
    chk("t2_b0", dec[0], 8'hA5);
    chk("t2_busy", busy_cnt, 44);

    // Slave NACKs the second byte
    launch(24'h5AC3F0, 2'd3, 1);
    wait_fin();
    chk("t3_b0", dec[0], 8'h5A);
    chk("t3_b1", dec[1], 8'hC3);
`ifdef I2C_ACK_CHECK_EN
    chk("t3_rises", rises, 18);
    chk("t3_busy", busy_cnt, 80);
    chk("t3_nack", nack, 1);
`else
    chk("t3_rises", rises, 27);
    chk("t3_busy", busy_cnt, 116);
    chk("t3_nack", nack, 0);
`endif
    repeat (10) step();

    // Start and data changes during a transaction are ignored
    launch(24'hC35A81, 2'd3, -1);
    data = 24'hFFFFFF; len = 2'd1;
    repeat (30) step();
    start = 1'b1; step(); start = 1'b0;
    wait_fin();
    chk("t4_rises", rises, 27);
    chk("t4_b0", dec[0], 8'hC3);
    chk("t4_b1", dec[1], 8'h5A);
    chk("t4_b2", dec[2], 8'h81);
    chk("t4_busy", busy_cnt, 116);

    // Zero-length request
    b0 = n_busy_rise; l0 = scl_low_cnt;
    launch(24'h123456, 2'd0, -1);
    chk("t5_fin", fin, 1);
    chk("t5_busy", busy, 0);
    repeat (5) step();
    chk("t5_busy_rise", n_busy_rise - b0, 0);
    chk("t5_scl_low", scl_low_cnt - l0, 0);

    // Reset during byte 1
    p0 = n_stop;
    launch(24'h123456, 2'd3, -1);
    repeat (39) step();
    rst_n = 1'b0;
    #1;
    chk("t6_scl", scl, 1);
    chk("t6_sda", sda, 1);
    chk("t6_busy", busy, 0);
    chk("t6_fin", fin, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("t6_no_stop", n_stop - p0, 0);
    launch(24'h0FF055, 2'd3, -1);
    wait_fin();
    chk("t6_b0", dec[0], 8'h0F);
    chk("t6_b1", dec[1], 8'hF0);
    chk("t6_b2", dec[2], 8'h55);
    chk("t6_busy2", busy_cnt, 116);

    // Start held high across the completion pulse
    s0 = n_start;
    nack_at = -1; data = 24'hA50000; len = 2'd1; start = 1'b1;
    step();
    begin
      int k = 0;
      while (!fin && k < 1000) begin
        step(); k++;
      end
    end
    chk("t7_fin", fin, 1);
    step();
    chk("t7_busy", busy, 1);
    chk("t7_scl", scl, 1);
    chk("t7_sda", sda, 0);
    start = 1'b0;
    wait_fin();
    chk("t7_starts", n_start - s0, 2);
    chk("t7_b0", dec[0], 8'hA5);
    chk("t7_busy_len", busy_cnt, 44);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
